// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU round-robin sequencer: op codes, FSM states,
// op-to-selector mapping and a saturating counter helper.
package alu_ctrl_pkg;

   localparam int unsigned SEL_W = 7;

   localparam logic [2:0] OP_AND     = 3'd0;
   localparam logic [2:0] OP_OR      = 3'd1;
   localparam logic [2:0] OP_NOT     = 3'd2;
   localparam logic [2:0] OP_XOR     = 3'd3;
   localparam logic [2:0] OP_ADD     = 3'd4;
   localparam logic [2:0] OP_SUB     = 3'd5;
   localparam logic [2:0] OP_MULT    = 3'd6;
   localparam logic [2:0] OP_ILLEGAL = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ISSUE = 2'b01,
      S_WAIT  = 2'b10,
      S_RESP  = 2'b11
   } state_e;

   // Selector bit order {mult,sub,add,xor,not,or,and} matches the op-code value.
   function automatic logic [SEL_W-1:0] op_to_sel(input logic [2:0] op);
      logic [SEL_W-1:0] sel;
      sel = '0;
      if (op != OP_ILLEGAL) begin
         sel[op] = 1'b1;
      end
      return sel;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] val);
      return (val == 8'hff) ? val : val + 8'd1;
   endfunction

endpackage

// File: rtl/alu_rr_sequencer_if.sv
// Request, ALU-drive and response signals of the ALU round-robin sequencer.
// slave: the sequencer; master: requesters plus the ALU datapath.
interface alu_rr_sequencer_if #(
   parameter int unsigned W = 8
) ();

   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [2:0]   req_op0;
   logic [2:0]   req_op1;
   logic [W-1:0] req_a0;
   logic [W-1:0] req_b0;
   logic [W-1:0] req_a1;
   logic [W-1:0] req_b1;

   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [6:0]   alu_sel;
   logic [W-1:0] alu_result;
   logic         alu_overflow;

   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_id;
   logic [W-1:0] rsp_data;
   logic         rsp_error;

   modport slave (
      input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
      input  alu_result, alu_overflow, rsp_ready,
      output req_ready, alu_a, alu_b, alu_sel,
      output rsp_valid, rsp_id, rsp_data, rsp_error
   );

   modport master (
      output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
      output alu_result, alu_overflow, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_sel,
      input  rsp_valid, rsp_id, rsp_data, rsp_error
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. A grant is always a completed handshake,
// so the last-winner pointer advances on every grant.
module rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o,
   output logic       gnt_id_o,
   output logic       upd_o
);

   logic last_q;
   logic win_id;

   always_comb begin
      win_id = ~last_q;
      case (req_i)
         2'b01:   win_id = 1'b0;
         2'b10:   win_id = 1'b1;
         default: win_id = ~last_q;
      endcase
   end

   assign upd_o    = en_i & (|req_i);
   assign gnt_id_o = win_id;
   assign gnt_o    = upd_o ? (win_id ? 2'b10 : 2'b01) : 2'b00;

   // Resets to 1 so requester 0 wins the first contested cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q <= 1'b1;
      end else if (upd_o) begin
         last_q <= win_id;
      end
   end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer sharing one ALU between two requesters.
// Define ALU_RR_STATS_EN to build the saturating response/error counters.
module alu_rr_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   alu_rr_sequencer_if.slave   bus,
   output logic                busy,
   output logic [7:0]          stat_ops0,
   output logic [7:0]          stat_ops1,
   output logic [7:0]          stat_err
);

   state_e           state_q;
   logic [2:0]       op_q;
   logic [W-1:0]     alu_a_q;
   logic [W-1:0]     alu_b_q;
   logic [SEL_W-1:0] alu_sel_q;
   logic             rsp_valid_q;
   logic             rsp_id_q;
   logic [W-1:0]     rsp_data_q;
   logic             rsp_error_q;

   logic             arb_en;
   logic             accept;
   logic             gnt_id;
   logic [1:0]       gnt;
   logic [2:0]       acc_op;
   logic [W-1:0]     acc_a;
   logic [W-1:0]     acc_b;

   assign arb_en = en & ~rst & (state_q == S_IDLE);

   rr_arb2 u_arb (
      .clk_i    (clk),
      .rst_i    (rst),
      .en_i     (arb_en),
      .req_i    (bus.req_valid),
      .gnt_o    (gnt),
      .gnt_id_o (gnt_id),
      .upd_o    (accept)
   );

   assign acc_op = gnt_id ? bus.req_op1 : bus.req_op0;
   assign acc_a  = gnt_id ? bus.req_a1  : bus.req_a0;
   assign acc_b  = gnt_id ? bus.req_b1  : bus.req_b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= OP_AND;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  op_q     <= acc_op;
                  rsp_id_q <= gnt_id;
                  // Illegal ops never touch the ALU and answer immediately.
                  if (acc_op == OP_ILLEGAL) begin
                     rsp_data_q  <= '0;
                     rsp_error_q <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state_q     <= S_RESP;
                  end else begin
                     alu_a_q   <= acc_a;
                     alu_b_q   <= acc_b;
                     alu_sel_q <= op_to_sel(acc_op);
                     state_q   <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               rsp_data_q  <= bus.alu_result;
               rsp_error_q <= (op_q == OP_MULT) & bus.alu_overflow;
               alu_sel_q   <= '0;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.req_ready = gnt;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_sel   = alu_sel_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_error = rsp_error_q;
   assign busy          = (state_q != S_IDLE);

`ifdef ALU_RR_STATS_EN
   logic [7:0] stat_ops0_q;
   logic [7:0] stat_ops1_q;
   logic [7:0] stat_err_q;
   logic       rsp_hs;

   assign rsp_hs = rsp_valid_q & bus.rsp_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_ops0_q <= '0;
         stat_ops1_q <= '0;
         stat_err_q  <= '0;
      end else if (rsp_hs) begin
         if (!rsp_id_q) stat_ops0_q <= sat_inc8(stat_ops0_q);
         if (rsp_id_q)  stat_ops1_q <= sat_inc8(stat_ops1_q);
         if (rsp_error_q) stat_err_q <= sat_inc8(stat_err_q);
      end
   end

   assign stat_ops0 = stat_ops0_q;
   assign stat_ops1 = stat_ops1_q;
   assign stat_err  = stat_err_q;
`else
   assign stat_ops0 = '0;
   assign stat_ops1 = '0;
   assign stat_err  = '0;
`endif

endmodule

// File: doc/alu_rr_sequencer.md
# alu_rr_sequencer

Two-port round-robin controller that shares the single 8-bit ALU datapath (operand registers, AND/OR/NOT/XOR/ADD/SUB/MULT units, one-hot output mux) between two requesters. Each requester posts an encoded operation with two operands over a valid/ready handshake. The block arbitrates, drives the ALU operand and one-hot op-select inputs, captures the result and overflow flag, and returns a tagged response on a single backpressured response channel. It sits between the requesting logic and the ALU top level, replacing direct drive of the ALU's operand and selector inputs.

## Interface
- `W`, 8: operand/result width; must match the ALU datapath.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: global enable; when low no new grant is issued, an in-flight operation completes.
- `req_valid` in 2: per-requester request valid, bit i = requester i.
- `req_ready` out 2: per-requester accept; at most one bit high per cycle.
- `req_op0`, `req_op1` in 3 each: op code: 0 AND, 1 OR, 2 NOT, 3 XOR, 4 ADD, 5 SUB, 6 MULT, 7 illegal.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in W each: operands.
- `alu_a`, `alu_b` out W: registered operands to the ALU operand DFFs.
- `alu_sel` out 7: registered one-hot selector; bit order {mult,sub,add,xor,not,or,and} = bits 6..0.
- `alu_result` in W: ALU output, valid the cycle after the operands are presented.
- `alu_overflow` in 1: multiplier overflow, same timing as `alu_result`.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_id` out 1: requester index of the response.
- `rsp_data` out W: result.
- `rsp_error` out 1: illegal op, or overflow on MULT.
- `busy` out 1: high in any state other than IDLE.
- `stat_ops0`, `stat_ops1`, `stat_err` out 8 each: statistics counters (see Configuration).

## Operation
- States: IDLE, ISSUE, WAIT, RESP (2-bit encoding 00/01/10/11).
- IDLE: if `en` and any `req_valid`, assert `req_ready` for the winner, combinationally in the same cycle. The handshake latches op, operands and id, updates the round-robin pointer, and moves to ISSUE. If the op is illegal, it moves directly to RESP with `rsp_data`=0 and `rsp_error`=1.
- Round-robin: `last` pointer resets to 1, so requester 0 wins the first contested cycle. When both requesters are valid, the one not equal to `last` wins. A single valid requester always wins. `last` updates only on an accepted handshake.
- ISSUE: drive `alu_a`, `alu_b` and `alu_sel` (exactly one bit high). Go to WAIT.
- WAIT: capture `alu_result` into `rsp_data` and `alu_overflow` into `rsp_error`. Overflow is honoured only for MULT; for all other ops `rsp_error`=0. Go to RESP.
- RESP: hold `rsp_valid`=1 with data, id and error stable until `rsp_ready`. On the handshake, return to IDLE.
- `req_ready` is 0 in every state except IDLE, so only one operation is in flight at a time.
- NOT ignores `b`; the operand is still forwarded unchanged.
- `alu_sel` returns to all-zero whenever the state is not ISSUE or WAIT. `alu_a` and `alu_b` hold their last value.

## Timing
- Reset values: state IDLE; `req_ready`=0; `alu_a`=`alu_b`=0; `alu_sel`=0; `rsp_valid`=0; `rsp_id`=0; `rsp_data`=0; `rsp_error`=0; `busy`=0; `last`=1; stat counters 0.
- Latency: accept at cycle N, `alu_*` valid N+1, result captured at the end of N+2, `rsp_valid` high at N+3. Illegal op: `rsp_valid` high at N+1.
- Minimum spacing between accepts is 4 cycles with `rsp_ready` tied high. The first IDLE cycle after a response may accept again.
- `rst` asserted in any state returns to reset values on the next edge. An in-flight response is discarded.
- `en` deasserted mid-operation has no effect until IDLE is reached.
- `rsp_ready` held low stalls indefinitely in RESP. Requesters see `req_ready`=0 throughout the stall.

## Configuration
- `ALU_RR_STATS_EN` defined: `stat_ops0` and `stat_ops1` increment on each completed response handshake for that id. `stat_err` increments on each response with `rsp_error`=1. All three are 8-bit, saturate at 255 and clear on `rst`.
- Undefined: the counters are not built and the three outputs are tied to 0. Ports remain present.

## Structure
- Shared package `alu_ctrl_pkg` holds:
  - op-code constants (OP_AND…OP_MULT, OP_ILLEGAL=7);
  - state constants S_IDLE/S_ISSUE/S_WAIT/S_RESP;
  - a function mapping the 3-bit op to the 7-bit one-hot `alu_sel` (0 for illegal).
- One sub-module, `rr_arb2`: two-requester round-robin arbiter with `last` pointer, grant output and update strobe.
- Everything else lives in the top module.

## Test plan
- Requester 0 ADD a=100, b=27, `rsp_ready`=1: `req_ready`=01 at N, `alu_sel`=0010000 at N+1, `rsp_valid` at N+3 with data 127, id 0, error 0.
- Both valid continuously with MULT 3×5 and SUB 9−4: grants alternate 0,1,0,1. The first response is id 0 with 15, the next is id 1 with 5.
- Requester 1 MULT 20×20: `rsp_data`=400 mod 256 = 144, `rsp_error`=1. With stats enabled, `stat_err` increments.
- Illegal op 7 from requester 0: no `alu_sel` pulse; `rsp_valid` at N+1 with data 0, error 1.
- `rsp_ready` held low for 10 cycles in RESP: response stable, `req_ready`=00 throughout. Release: handshake, then IDLE and a new accept on the following cycle.
- `rst` pulsed during WAIT: next cycle all outputs at reset values, no response emitted, `last`=1.
